// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, RV32 load/store funct3 codes and the
// access-legality helpers used by data_mem_ctrl.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Natural alignment: halves need addr[0]=0, words need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Stores only have SB/SH/SW; loads have LB/LH/LW/LBU/LHU.
   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      if (we) begin
         ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end else begin
         ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering. The store side turns a
// right-aligned store into a byte-enable mask plus replicated data; the load
// side picks the addressed byte/half out of a word and sign/zero extends it.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  st_funct3_i,
   input  logic [1:0]  st_addr_lo_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_addr_lo_i,
   input  logic [31:0] ld_word_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  lane [4];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = ld_word_i[8*gi +: 8];
   end

   assign ld_byte = lane[ld_addr_lo_i];
   assign ld_half = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

   // Store: data is replicated across lanes so the enable mask alone picks the target.
   always_comb begin
      st_be_o    = 4'b0000;
      st_wdata_o = st_wdata_i;
      case (st_funct3_i)
         F3_B: begin
            st_be_o    = 4'b0001 << st_addr_lo_i;
            st_wdata_o = {4{st_wdata_i[7:0]}};
         end
         F3_H: begin
            st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
            st_wdata_o = {2{st_wdata_i[15:0]}};
         end
         F3_W:    st_be_o = 4'b1111;
         default: st_be_o = 4'b0000;
      endcase
   end

   // Load: lane select followed by sign or zero extension.
   always_comb begin
      ld_data_o = 32'h0;
      case (ld_funct3_i)
         F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data_o = {24'h0, ld_byte};
         F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data_o = {16'h0, ld_half};
         F3_W:    ld_data_o = ld_word_i;
         default: ld_data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 data memory with valid/ready request and response
// channels, one outstanding access, programmable wait states and fault
// detection (misaligned, out of range, illegal funct3).
// Build option DMEM_RESET_CLEAR_EN: when defined, reset also zeroes every
// memory word; otherwise contents survive reset.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_e       state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              accept;

   logic [29:0]       word_off;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              acc_err;
   logic              wr_en;

   logic [3:0]        st_be;
   logic [31:0]       st_wdata;
   logic [31:0]       ld_data;

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic [31:0]       rd_word_q;
   logic [2:0]        ld_funct3_q;
   logic [1:0]        ld_addr_lo_q;
   logic              ld_ok_q;
   logic              rsp_err_q;

   // BASE_ADDR is aligned to the array size, so the low two bits never borrow.
   assign word_off = req_addr[31:2] - BASE_ADDR[31:2];
   assign in_range = (req_addr >= BASE_ADDR) && (word_off < 30'(DEPTH_WORDS));
   assign idx      = word_off[IDX_W-1:0];
   assign acc_err  = !funct3_legal(req_we, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]) || !in_range;
   assign wr_en    = accept && req_we && !acc_err;

   dmem_lane_align u_align (
      .st_funct3_i  (req_funct3),
      .st_addr_lo_i (req_addr[1:0]),
      .st_wdata_i   (req_wdata),
      .st_be_o      (st_be),
      .st_wdata_o   (st_wdata),
      .ld_funct3_i  (ld_funct3_q),
      .ld_addr_lo_i (ld_addr_lo_q),
      .ld_word_i    (rd_word_q),
      .ld_data_o    (ld_data)
   );

   // Next-state and handshake outputs; nothing is accepted or offered during reset.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = !reset;
            if (req_valid && !reset) begin
               accept = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            rsp_valid = !reset;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Response attributes latched at acceptance and held until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_err_q    <= 1'b0;
         ld_ok_q      <= 1'b0;
         ld_funct3_q  <= 3'b000;
         ld_addr_lo_q <= 2'b00;
      end else if (accept) begin
         rsp_err_q    <= acc_err;
         ld_ok_q      <= !req_we && !acc_err;
         ld_funct3_q  <= req_funct3;
         ld_addr_lo_q <= req_addr[1:0];
      end
   end

   // Storage: byte-enabled write and registered read, both on the acceptance edge.
   always_ff @(posedge clk) begin
`ifdef DMEM_RESET_CLEAR_EN
      if (reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            mem_q[i] <= 32'h0;
         end
      end else
`endif
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
               mem_q[idx][8*b +: 8] <= st_wdata[8*b +: 8];
            end
         end
      end
      if (accept) begin
         rd_word_q <= mem_q[idx];
      end
   end

   // Faulted accesses and stores return zero data.
   assign rsp_rdata = ld_ok_q ? ld_data : 32'h0;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: two instances (no wait states / three wait states with a
// non-zero base) checked against a byte-array reference model, a directed
// vector table, a reset-during-WAIT sequence and randomized traffic.
module tb_data_mem_ctrl;
   import dmem_pkg::*;

   localparam int          DEPTH0 = 32;
   localparam logic [31:0] BASE0  = 32'h0000_0000;
   localparam int          WS0    = 0;
   localparam int          DEPTH3 = 16;
   localparam logic [31:0] BASE3  = 32'h0000_1000;
   localparam int          WS3    = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid_v = 2'b00;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_ready = 1'b0;
   logic [1:0]  req_ready_v, rsp_valid_v, rsp_err_v;
   logic [31:0] rdata0, rdata3;

   int checks = 0;
   int failures = 0;

   logic [7:0] mdl [2][128];

   typedef struct {
      int          sel;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] off;
      logic [31:0] wd;
      int          stall;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata0), .rsp_err(rsp_err_v[0])
   );

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH3), .BASE_ADDR(BASE3), .WAIT_STATES(WS3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata3), .rsp_err(rsp_err_v[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: memory as a flat byte array, accesses by size and offset.
   function automatic void model(input int sel, input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic err);
      int          size;
      logic [31:0] base, off, v;
      int          span;
      bit          legal;
      base = (sel != 0) ? BASE3 : BASE0;
      span = ((sel != 0) ? DEPTH3 : DEPTH0) * 4;
      case (f3[1:0])
         2'd0:    size = 1;
         2'd1:    size = 2;
         2'd2:    size = 4;
         default: size = 0;
      endcase
      legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      rd  = 32'h0;
      err = 1'b0;
      if (!legal) begin
         err = 1'b1;
         return;
      end
      off = addr - base;
      if (addr < base || off >= 32'(span) || (addr % 32'(size)) != 0) begin
         err = 1'b1;
         return;
      end
      if (we) begin
         for (int i = 0; i < size; i++) mdl[sel][int'(off) + i] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(mdl[sel][int'(off) + i]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
         rd = v;
      end
   endfunction

   // One full request/response exchange with protocol and data checks.
   task automatic txn(input int sel, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall, input logic [31:0] exp_rd,
                      input logic exp_err, input string name);
      int          n;
      int          lat;
      int          ws;
      logic [31:0] rd;
      ws = (sel != 0) ? WS3 : WS0;
      n = 0;
      while (!req_ready_v[sel] && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check({name, "/req_ready"}, 32'(req_ready_v[sel]), 32'd1);
      if (!req_ready_v[sel]) return;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid_v[sel] = 1'b1;
      @(posedge clk); #1;
      req_valid_v = 2'b00;
      lat = 1;
      while (!rsp_valid_v[sel] && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check({name, "/latency"}, 32'(lat), 32'(ws + 1));
      if (!rsp_valid_v[sel]) return;
      rd = (sel != 0) ? rdata3 : rdata0;
      check({name, "/rdata"}, rd, exp_rd);
      check({name, "/err"}, 32'(rsp_err_v[sel]), 32'(exp_err));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check({name, "/stall_valid"}, 32'(rsp_valid_v[sel]), 32'd1);
         check({name, "/stall_rdata"}, (sel != 0) ? rdata3 : rdata0, exp_rd);
         check({name, "/stall_ready"}, 32'(req_ready_v[sel]), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({name, "/post_valid"}, 32'(rsp_valid_v[sel]), 32'd0);
      check({name, "/post_ready"}, 32'(req_ready_v[sel]), 32'd1);
      $display("txn %s sel=%0d we=%0d f3=%0d addr=%h rdata=%h err=%0d",
               name, sel, we, f3, addr, rd, rsp_err_v[sel]);
   endtask

   task automatic add_vec(input int sel, input bit we, input logic [2:0] f3, input logic [31:0] off,
                          input logic [31:0] wd, input int stall, input logic [31:0] exp_rd,
                          input logic exp_err);
      vec_t v;
      v.sel = sel; v.we = we; v.f3 = f3; v.off = off; v.wd = wd;
      v.stall = stall; v.exp_rd = exp_rd; v.exp_err = exp_err;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] erd, addr, base, wd;
      logic        eerr;
      int          sel, span, r, stall;
      bit          we;
      logic [2:0]  f3;

      // Directed vectors
      add_vec(0, 1, F3_W,   32'h10, 32'hDEADBEEF, 0, 32'h0,        0);
      add_vec(0, 0, F3_W,   32'h10, 32'h0,        0, 32'hDEADBEEF, 0);
      add_vec(0, 1, F3_W,   32'h20, 32'h80FF7F01, 0, 32'h0,        0);
      add_vec(0, 0, F3_B,   32'h23, 32'h0,        1, 32'hFFFFFF80, 0);
      add_vec(0, 0, F3_BU,  32'h23, 32'h0,        0, 32'h00000080, 0);
      add_vec(0, 0, F3_H,   32'h22, 32'h0,        0, 32'hFFFF80FF, 0);
      add_vec(0, 0, F3_HU,  32'h20, 32'h0,        2, 32'h00007F01, 0);
      add_vec(0, 0, F3_B,   32'h20, 32'h0,        0, 32'h00000001, 0);
      add_vec(0, 0, F3_H,   32'h21, 32'h0,        0, 32'h0,        1);
      add_vec(0, 1, F3_W,   32'h08, 32'h11223344, 0, 32'h0,        0);
      add_vec(0, 1, F3_B,   32'h09, 32'h123456AA, 0, 32'h0,        0);
      add_vec(0, 1, F3_H,   32'h0A, 32'hFFFFBEEF, 0, 32'h0,        0);
      add_vec(0, 0, F3_W,   32'h08, 32'h0,        0, 32'hBEEFAA44, 0);
      add_vec(0, 1, F3_W,   32'h00, 32'h0BADF00D, 0, 32'h0,        0);
      add_vec(0, 1, F3_W,   32'h04, 32'h55667788, 0, 32'h0,        0);
      add_vec(0, 0, F3_W,   32'h06, 32'h0,        0, 32'h0,        1);
      add_vec(0, 1, F3_H,   32'h05, 32'h0000FFFF, 0, 32'h0,        1);
      add_vec(0, 0, F3_W,   32'h04, 32'h0,        0, 32'h55667788, 0);
      add_vec(0, 0, F3_W,   32'h80, 32'h0,        0, 32'h0,        1);
      add_vec(0, 1, F3_W,   32'h80, 32'hFFFFFFFF, 0, 32'h0,        1);
      add_vec(0, 0, F3_W,   32'h00, 32'h0,        0, 32'h0BADF00D, 0);
      add_vec(0, 0, 3'b011, 32'h04, 32'h0,        0, 32'h0,        1);
      add_vec(0, 1, 3'b011, 32'h04, 32'hFFFFFFFF, 0, 32'h0,        1);
      add_vec(0, 1, 3'b100, 32'h04, 32'hFFFFFFFF, 0, 32'h0,        1);
      add_vec(0, 0, F3_W,   32'h04, 32'h0,        0, 32'h55667788, 0);
      add_vec(1, 1, F3_W,   32'h08, 32'hCAFEF00D, 0, 32'h0,        0);
      add_vec(1, 0, F3_W,   32'h08, 32'h0,        5, 32'hCAFEF00D, 0);
      add_vec(1, 0, F3_B,   32'h0B, 32'h0,        2, 32'hFFFFFFCA, 0);
      add_vec(1, 0, F3_W,   32'hFFFFFFFC, 32'h0,  0, 32'h0,        1);
      add_vec(1, 0, F3_W,   32'h40, 32'h0,        1, 32'h0,        1);

      // Reset values
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("reset/req_ready", 32'(req_ready_v[s]), 32'd0);
         check("reset/rsp_valid", 32'(rsp_valid_v[s]), 32'd0);
         check("reset/rsp_err",   32'(rsp_err_v[s]),   32'd0);
      end
      check("reset/rdata0", rdata0, 32'h0);
      check("reset/rdata3", rdata3, 32'h0);
      reset = 1'b0;
      #1;
      check("release/req_ready0", 32'(req_ready_v[0]), 32'd1);
      check("release/req_ready3", 32'(req_ready_v[1]), 32'd1);

      // Give every word a known value
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < ((s != 0) ? DEPTH3 : DEPTH0); w++) begin
            base = (s != 0) ? BASE3 : BASE0;
            wd = $urandom;
            model(s, 1'b1, F3_W, base + 32'(4*w), wd, erd, eerr);
            txn(s, 1'b1, F3_W, base + 32'(4*w), wd, 0, erd, eerr, "fill");
         end
      end

      // Table
      foreach (vecs[k]) begin
         base = (vecs[k].sel != 0) ? BASE3 : BASE0;
         model(vecs[k].sel, vecs[k].we, vecs[k].f3, base + vecs[k].off, vecs[k].wd, erd, eerr);
         txn(vecs[k].sel, vecs[k].we, vecs[k].f3, base + vecs[k].off, vecs[k].wd,
             vecs[k].stall, vecs[k].exp_rd, vecs[k].exp_err, $sformatf("vec%0d", k));
      end

      // Reset while the WS=3 instance sits in WAIT after a store
      check("rw/idle_ready", 32'(req_ready_v[1]), 32'd1);
      req_we = 1'b1; req_funct3 = F3_W; req_addr = BASE3 + 32'h4; req_wdata = 32'h12345678;
      req_valid_v[1] = 1'b1;
      @(posedge clk); #1;
      req_valid_v = 2'b00;
      model(1, 1'b1, F3_W, BASE3 + 32'h4, 32'h12345678, erd, eerr);
      check("rw/in_wait_valid", 32'(rsp_valid_v[1]), 32'd0);
      reset = 1'b1;
      #1;
      check("rw/reset_valid", 32'(rsp_valid_v[1]), 32'd0);
      check("rw/reset_ready", 32'(req_ready_v[1]), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("rw/after_ready", 32'(req_ready_v[1]), 32'd1);
      check("rw/after_rdata", rdata3, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      check("rw/no_late_rsp", 32'(rsp_valid_v[1]), 32'd0);
`ifdef DMEM_RESET_CLEAR_EN
      for (int s = 0; s < 2; s++) for (int b = 0; b < 128; b++) mdl[s][b] = 8'h00;
      txn(1, 1'b0, F3_W, BASE3 + 32'h4, 32'h0, 0, 32'h00000000, 1'b0, "rw_load");
`else
      txn(1, 1'b0, F3_W, BASE3 + 32'h4, 32'h0, 0, 32'h12345678, 1'b0, "rw_load");
`endif
      model(0, 1'b0, F3_W, BASE0 + 32'h8, 32'h0, erd, eerr);
      txn(0, 1'b0, F3_W, BASE0 + 32'h8, 32'h0, 0, erd, eerr, "rw_load0");

      // Randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         sel   = int'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         wd    = $urandom;
         stall = int'($urandom_range(0, 2));
         base  = (sel != 0) ? BASE3 : BASE0;
         span  = ((sel != 0) ? DEPTH3 : DEPTH0) * 4;
         r     = int'($urandom_range(0, 9));
         if (r == 0)      addr = base + 32'(span) + 32'($urandom_range(0, 7));
         else if (r == 1) addr = base - 32'($urandom_range(1, 8));
         else             addr = base + 32'($urandom_range(0, span - 1));
         model(sel, we, f3, addr, wd, erd, eerr);
         txn(sel, we, f3, addr, wd, stall, erd, eerr, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
